// File: rtl/mesh_output_arbiter_if.sv
// Router-side bundle for one mesh output channel: requester side and
// downstream link side of the output arbiter.
interface mesh_output_arbiter_if #(
  parameter int NUM_REQ      = 5,
  parameter int PACKET_WIDTH = 64,
  parameter int CNT_WIDTH    = 16
);
  logic                            polarity;
  logic                            phase_sel;
  logic [NUM_REQ-1:0]              req;
  logic [NUM_REQ*PACKET_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]              gnt;
  logic                            out_ro;
  logic                            out_so;
  logic [PACKET_WIDTH-1:0]         out_do;
  logic [CNT_WIDTH-1:0]            grant_cnt;
  logic [2:0]                      last_gnt;

  modport master (
    output polarity, phase_sel, req, req_data, out_ro,
    input  gnt, out_so, out_do, grant_cnt, last_gnt
  );

  modport slave (
    input  polarity, phase_sel, req, req_data, out_ro,
    output gnt, out_so, out_do, grant_cnt, last_gnt
  );
endinterface

// File: rtl/mesh_output_arbiter.sv
// Round-robin arbiter plus output register sharing one outbound mesh link
// between the cw/ccw/sn/ns/pe input buffers, gated by polarity and ready.
module mesh_output_arbiter #(
  parameter int NUM_REQ      = 5,
  parameter int PACKET_WIDTH = 64,
  parameter int CNT_WIDTH    = 16
) (
  input logic              clk,
  input logic              rst,
  mesh_output_arbiter_if.slave bus
);

  logic                    arb_en;
  logic                    found;
  logic [NUM_REQ-1:0]      gnt_d;
  logic [2:0]              win;

  logic                    out_so_q, out_so_d;
  logic [PACKET_WIDTH-1:0] out_do_q, out_do_d;
  logic [CNT_WIDTH-1:0]    grant_cnt_q, grant_cnt_d;
  logic [2:0]              last_gnt_q, last_gnt_d;

  function automatic int rr_idx(input logic [2:0] base, input int k);
    return (int'(base) + k) % NUM_REQ;
  endfunction

  // Search starts just past the last winner, so the winner drops to lowest priority.
  always_comb begin
    arb_en = (bus.polarity == bus.phase_sel) && bus.out_ro && (|bus.req) && !rst;
    gnt_d  = '0;
    win    = '0;
    found  = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (arb_en && !found && bus.req[rr_idx(last_gnt_q, k)]) begin
        gnt_d[rr_idx(last_gnt_q, k)] = 1'b1;
        win   = 3'(rr_idx(last_gnt_q, k));
        found = 1'b1;
      end
    end
  end

  always_comb begin
    out_so_d    = arb_en;
    out_do_d    = out_do_q;
    grant_cnt_d = grant_cnt_q;
    last_gnt_d  = last_gnt_q;
    if (arb_en) begin
      out_do_d    = bus.req_data[int'(win)*PACKET_WIDTH +: PACKET_WIDTH];
      grant_cnt_d = grant_cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      last_gnt_d  = win;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_so_q    <= 1'b0;
      out_do_q    <= '0;
      grant_cnt_q <= '0;
      last_gnt_q  <= 3'(NUM_REQ-1);
    end else begin
      out_so_q    <= out_so_d;
      out_do_q    <= out_do_d;
      grant_cnt_q <= grant_cnt_d;
      last_gnt_q  <= last_gnt_d;
    end
  end

  assign bus.gnt       = gnt_d;
  assign bus.out_so    = out_so_q;
  assign bus.out_do    = out_do_q;
  assign bus.grant_cnt = grant_cnt_q;
  assign bus.last_gnt  = last_gnt_q;

endmodule
